// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: result-source select, load size and the load signedness bit.
// Also used by MEM-stage logic that decodes the same ld_op field.
package wb_stage_pkg;

    localparam logic [1:0] RES_SEL_ALU = 2'b00;
    localparam logic [1:0] RES_SEL_MEM = 2'b01;
    localparam logic [1:0] RES_SEL_CSR = 2'b10;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10,
        LD_D = 2'b11
    } ld_size_e;

    localparam int LD_UNSIGNED_BIT = 2;

endpackage

// File: rtl/wb_stage_ld_extend.sv
// Combinational sub-word load extract: shift the addressed lane down, mask to size, sign/zero-extend.
// Zero latency; no flow control. Misaligned offsets are not checked.
module ld_extend
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        ld_op,
    input  logic [2:0]        addr_lo,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] ext
);

    logic [2:0]        byte_off;
    logic [5:0]        sh;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign;

    always_comb begin
        byte_off = (DATA_W == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
        sh       = '0;
        mask     = '1;
        case (ld_size_e'(ld_op[1:0]))
            LD_B: begin
                sh   = {byte_off, 3'b000};
                mask = DATA_W'(8'hFF);
            end
            LD_H: begin
                sh   = {byte_off, 3'b000};
                mask = DATA_W'(16'hFFFF);
            end
            LD_W: begin
                sh   = (DATA_W == 64) ? {addr_lo[2], 5'b00000} : 6'd0;
                mask = DATA_W'(32'hFFFF_FFFF);
            end
            LD_D: begin
                sh   = '0;
                mask = '1;
            end
            default: begin
                sh   = '0;
                mask = '1;
            end
        endcase
        shifted = raw >> sh;
        // mask ^ (mask >> 1) isolates the top bit of the selected size, i.e. the sign position
        sign = !ld_op[LD_UNSIGNED_BIT] && (|(shifted & (mask ^ (mask >> 1))));
        ext  = (shifted & mask) | (sign ? ~mask : '0);
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM->WB register, result-source mux, load extend, exception flush, forwarding and trace.
// Latency 1 cycle MEM issue -> RF write; never stalls MEM (ws_allow_in=1 out of reset), drops the follower of a flush.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ms_to_ws_valid,
    output logic                ws_allow_in,
    input  logic [PC_W-1:0]     ms_pc,
    input  logic                ms_rf_we,
    input  logic [RF_AW-1:0]    ms_rf_waddr,
    input  logic [1:0]          ms_res_sel,
    input  logic [2:0]          ms_ld_op,
    input  logic [2:0]          ms_addr_lo,
    input  logic [DATA_W-1:0]   ms_alu_result,
    input  logic [DATA_W-1:0]   ms_mem_rdata,
    input  logic [DATA_W-1:0]   ms_csr_rdata,
    input  logic                ms_ex,
    input  logic [EXC_W-1:0]    ms_ex_code,
    output logic                rf_we,
    output logic [RF_AW-1:0]    rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                fwd_valid,
    output logic [RF_AW-1:0]    fwd_addr,
    output logic [DATA_W-1:0]   fwd_data,
    output logic                wb_flush,
    output logic [PC_W-1:0]     wb_ex_pc,
    output logic [EXC_W-1:0]    wb_ex_code,
    output logic [PC_W-1:0]     debug_wb_pc,
    output logic [DATA_W/8-1:0] debug_wb_rf_we,
    output logic [RF_AW-1:0]    debug_wb_rf_wnum,
    output logic [DATA_W-1:0]   debug_wb_rf_wdata
);

    localparam logic WS_READY_GO = 1'b1;

    logic              ws_valid_q,   ws_valid_d;
    logic [PC_W-1:0]   pc_q,         pc_d;
    logic              rf_we_q,      rf_we_d;
    logic [RF_AW-1:0]  waddr_q,      waddr_d;
    logic              is_ld_q,      is_ld_d;
    logic [2:0]        ld_op_q,      ld_op_d;
    logic [2:0]        addr_lo_q,    addr_lo_d;
    logic [DATA_W-1:0] res_q,        res_d;
    logic [DATA_W-1:0] mem_rdata_q,  mem_rdata_d;
    logic              ex_q,         ex_d;
    logic [EXC_W-1:0]  ex_code_q,    ex_code_d;

    logic              ws_live;
    logic              accept;
    logic [DATA_W-1:0] ld_data;

    ld_extend #(.DATA_W(DATA_W)) u_ld_extend (
        .ld_op   (ld_op_q),
        .addr_lo (addr_lo_q),
        .raw     (mem_rdata_q),
        .ext     (ld_data)
    );

    always_comb begin
        // gating with resetn suppresses the held instruction's write/flush during the reset cycle itself
        ws_live     = ws_valid_q && resetn;
        ws_allow_in = resetn && (!ws_valid_q || WS_READY_GO);
        wb_flush    = ws_live && ex_q;
        accept      = ws_allow_in && ms_to_ws_valid && !wb_flush;

        ws_valid_d  = accept;
        pc_d        = pc_q;
        rf_we_d     = rf_we_q;
        waddr_d     = waddr_q;
        is_ld_d     = is_ld_q;
        ld_op_d     = ld_op_q;
        addr_lo_d   = addr_lo_q;
        res_d       = res_q;
        mem_rdata_d = mem_rdata_q;
        ex_d        = ex_q;
        ex_code_d   = ex_code_q;
        if (accept) begin
            pc_d        = ms_pc;
            rf_we_d     = ms_rf_we;
            waddr_d     = ms_rf_waddr;
            is_ld_d     = (ms_res_sel == RES_SEL_MEM);
            ld_op_d     = ms_ld_op;
            addr_lo_d   = ms_addr_lo;
            // reserved select 11 falls through to the ALU result
            res_d       = (ms_res_sel == RES_SEL_CSR) ? ms_csr_rdata : ms_alu_result;
            mem_rdata_d = ms_mem_rdata;
            ex_d        = ms_ex;
            ex_code_d   = ms_ex_code;
        end

        rf_we             = ws_live && rf_we_q && !ex_q;
        rf_waddr          = waddr_q;
        rf_wdata          = is_ld_q ? ld_data : res_q;
        fwd_valid         = rf_we;
        fwd_addr          = rf_waddr;
        fwd_data          = rf_wdata;
        wb_ex_pc          = pc_q;
        wb_ex_code        = ex_code_q;
        debug_wb_pc       = pc_q;
        debug_wb_rf_we    = {(DATA_W/8){rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid_q  <= 1'b0;
            pc_q        <= '0;
            rf_we_q     <= 1'b0;
            waddr_q     <= '0;
            is_ld_q     <= 1'b0;
            ld_op_q     <= '0;
            addr_lo_q   <= '0;
            res_q       <= '0;
            mem_rdata_q <= '0;
            ex_q        <= 1'b0;
            ex_code_q   <= '0;
        end else begin
            ws_valid_q  <= ws_valid_d;
            pc_q        <= pc_d;
            rf_we_q     <= rf_we_d;
            waddr_q     <= waddr_d;
            is_ld_q     <= is_ld_d;
            ld_op_q     <= ld_op_d;
            addr_lo_q   <= addr_lo_d;
            res_q       <= res_d;
            mem_rdata_q <= mem_rdata_d;
            ex_q        <= ex_d;
            ex_code_q   <= ex_code_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (DATA_W=32): reset, ALU/CSR/load sources, streaming, exception flush, mid-stream reset.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allow_in;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [1:0]  ms_res_sel;
    logic [2:0]  ms_ld_op;
    logic [2:0]  ms_addr_lo;
    logic [31:0] ms_alu_result;
    logic [31:0] ms_mem_rdata;
    logic [31:0] ms_csr_rdata;
    logic        ms_ex;
    logic [5:0]  ms_ex_code;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        wb_flush;
    logic [31:0] wb_ex_pc;
    logic [5:0]  wb_ex_code;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allow_in       (ws_allow_in),
        .ms_pc             (ms_pc),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_res_sel        (ms_res_sel),
        .ms_ld_op          (ms_ld_op),
        .ms_addr_lo        (ms_addr_lo),
        .ms_alu_result     (ms_alu_result),
        .ms_mem_rdata      (ms_mem_rdata),
        .ms_csr_rdata      (ms_csr_rdata),
        .ms_ex             (ms_ex),
        .ms_ex_code        (ms_ex_code),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .fwd_valid         (fwd_valid),
        .fwd_addr          (fwd_addr),
        .fwd_data          (fwd_data),
        .wb_flush          (wb_flush),
        .wb_ex_pc          (wb_ex_pc),
        .wb_ex_code        (wb_ex_code),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc, input logic we, input logic [4:0] wa,
                         input logic [1:0] sel, input logic [2:0] op, input logic [2:0] alo,
                         input logic ex, input logic [5:0] code);
        ms_to_ws_valid = vld;
        ms_pc          = pc;
        ms_rf_we       = we;
        ms_rf_waddr    = wa;
        ms_res_sel     = sel;
        ms_ld_op       = op;
        ms_addr_lo     = alo;
        ms_ex          = ex;
        ms_ex_code     = code;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [2:0]  op;
        logic [2:0]  alo;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"lb0",   2'b01, 3'b000, 3'd0, 32'hFFFF_FF81};
        vecs[1] = '{"lbu0",  2'b01, 3'b100, 3'd0, 32'h0000_0081};
        vecs[2] = '{"lh2",   2'b01, 3'b001, 3'd2, 32'hFFFF_80FF};
        vecs[3] = '{"lhu2",  2'b01, 3'b101, 3'd2, 32'h0000_80FF};
        vecs[4] = '{"lb1",   2'b01, 3'b000, 3'd1, 32'h0000_007F};
        vecs[5] = '{"lb3",   2'b01, 3'b000, 3'd3, 32'hFFFF_FF80};
        vecs[6] = '{"lh0",   2'b01, 3'b001, 3'd0, 32'h0000_7F81};
        vecs[7] = '{"lw0",   2'b01, 3'b010, 3'd0, 32'h80FF_7F81};
        vecs[8] = '{"csr",   2'b10, 3'b000, 3'd0, 32'hCAFE_0001};
        vecs[9] = '{"rsvd",  2'b11, 3'b000, 3'd0, 32'h1234_5678};

        ms_alu_result = 32'h1234_5678;
        ms_mem_rdata  = 32'h80FF_7F81;
        ms_csr_rdata  = 32'hCAFE_0001;

        // reset held with a valid writer presented
        resetn = 1'b0;
        drive(1'b1, 32'h1C00_0000, 1'b1, 5'd3, 2'b00, 3'b000, 3'd0, 1'b1, 6'h02);
        repeat (3) step();
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_flush", 64'(wb_flush), 64'd0);
        chk("rst_dbg_we", 64'(debug_wb_rf_we), 64'd0);
        chk("rst_dbg_pc", 64'(debug_wb_pc), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 2'b00, 3'b000, 3'd0, 1'b0, 6'h00);
        resetn = 1'b1;
        #1;
        chk("allow_in", 64'(ws_allow_in), 64'd1);
        step();
        chk("idle_rf_we", 64'(rf_we), 64'd0);

        // single ALU op
        drive(1'b1, 32'h1C00_0010, 1'b1, 5'd5, 2'b00, 3'b000, 3'd0, 1'b0, 6'h00);
        step();
        chk("alu_we", 64'(rf_we), 64'd1);
        chk("alu_waddr", 64'(rf_waddr), 64'd5);
        chk("alu_wdata", 64'(rf_wdata), 64'h1234_5678);
        chk("alu_dbg_we", 64'(debug_wb_rf_we), 64'hF);
        chk("alu_dbg_pc", 64'(debug_wb_pc), 64'h1C00_0010);
        chk("alu_allow", 64'(ws_allow_in), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 2'b00, 3'b000, 3'd0, 1'b0, 6'h00);
        step();
        chk("bubble_we", 64'(rf_we), 64'd0);

        // load extract and source select, back-to-back
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1C00_0100 + 32'(i * 4), 1'b1, 5'(i + 10), vecs[i].sel, vecs[i].op,
                  vecs[i].alo, 1'b0, 6'h00);
            step();
            chk({vecs[i].name, "_we"}, 64'(rf_we), 64'd1);
            chk({vecs[i].name, "_data"}, 64'(rf_wdata), 64'(vecs[i].exp));
        end

        // eight consecutive ALU ops, forwarding port tracks every write
        for (int i = 0; i < 8; i++) begin
            ms_alu_result = 32'hA000_0000 + 32'(i * 32'h111);
            drive(1'b1, 32'h1C00_0200 + 32'(i * 4), 1'b1, 5'(i + 1), 2'b00, 3'b000, 3'd0, 1'b0, 6'h00);
            step();
            chk("str_we", 64'(rf_we), 64'd1);
            chk("str_waddr", 64'(rf_waddr), 64'(i + 1));
            chk("str_wdata", 64'(rf_wdata), 64'(32'hA000_0000 + 32'(i * 32'h111)));
            chk("str_fwd_vld", 64'(fwd_valid), 64'd1);
            chk("str_fwd_addr", 64'(fwd_addr), 64'(i + 1));
            chk("str_fwd_data", 64'(fwd_data), 64'(32'hA000_0000 + 32'(i * 32'h111)));
        end

        // exception with a valid follower
        drive(1'b1, 32'h1C00_0100, 1'b1, 5'd7, 2'b00, 3'b000, 3'd0, 1'b1, 6'h0B);
        step();
        chk("ex_flush", 64'(wb_flush), 64'd1);
        chk("ex_pc", 64'(wb_ex_pc), 64'h1C00_0100);
        chk("ex_code", 64'(wb_ex_code), 64'h0B);
        chk("ex_rf_we", 64'(rf_we), 64'd0);
        drive(1'b1, 32'h1C00_0104, 1'b1, 5'd9, 2'b00, 3'b000, 3'd0, 1'b0, 6'h00);
        step();
        chk("ex_pulse_end", 64'(wb_flush), 64'd0);
        chk("follower_we", 64'(rf_we), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 2'b00, 3'b000, 3'd0, 1'b0, 6'h00);
        step();
        chk("follower_late", 64'(rf_we), 64'd0);
        chk("post_ex_flush", 64'(wb_flush), 64'd0);

        // reset while a load is held
        drive(1'b1, 32'h1C00_0300, 1'b1, 5'd12, 2'b01, 3'b000, 3'd0, 1'b0, 6'h00);
        step();
        chk("held_ld_we", 64'(rf_we), 64'd1);
        chk("held_ld_data", 64'(rf_wdata), 64'hFFFF_FF81);
        resetn = 1'b0;
        #1;
        chk("mid_rst_we_now", 64'(rf_we), 64'd0);
        step();
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_flush", 64'(wb_flush), 64'd0);
        chk("mid_rst_dbg_pc", 64'(debug_wb_pc), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 2'b00, 3'b000, 3'd0, 1'b0, 6'h00);
        resetn = 1'b1;
        step();
        chk("post_rst_we", 64'(rf_we), 64'd0);
        chk("post_rst_allow", 64'(ws_allow_in), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
